uart_tx: RTL and testbench

//  - Serialises one byte per request onto the UART TX line: 8N1 (1 start, 8 data LSB-first, 1 stop).
//  - Sits at the serial boundary of the comms path, opposite end of the link from the UART receiver.
//  - Fixed baud; one frame at a time; no buffering beyond the active frame.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_if.sv | 9 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx.sv | 86 ++++++++
 tb/tb_uart_tx.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter and the receiver.
// Defining UART_TX_PARITY_EN adds an even-parity bit, which gives an 11-bit frame.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } state_t;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 2604;
    localparam int          BAUD_CNT_W           = 12;
    localparam int          BIT_CNT_W            = 4;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // The frame ends on the baud tick that closes this bit index (the stop bit).
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level request/completion handshake between a host and uart_tx.
interface uart_tx_if;
    logic       trmt;
    logic [7:0] tx_data;
    logic       tx_done;

    modport master (output trmt, output tx_data, input tx_done);
    modport slave  (input trmt, input tx_data, output tx_done);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period timer that produces a one-cycle strobe every CLKS_PER_BIT cycles while it is not held clear.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [BAUD_CNT_W-1:0] TERMINAL = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = !clear_i && (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: sends one 8N1 frame per accepted trmt and sets a sticky tx_done when the frame ends.
// Defining UART_TX_PARITY_EN inserts an even-parity bit after data bit 7.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_tx_if.slave host,
    output logic     TX
);

    state_t                state_q, state_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0]  bitCnt_q, bitCnt_d;
    logic                  done_q, done_d;
    logic                  baudTick;
    logic                  baudClear;
    logic [FRAME_BITS-1:0] loadFrame;

`ifdef UART_TX_PARITY_EN
    assign loadFrame = {1'b1, ^host.tx_data, host.tx_data, 1'b0};
`else
    assign loadFrame = {1'b1, host.tx_data, 1'b0};
`endif

    // The baud timer is held at zero outside a frame, so every frame starts with a full bit period.
    assign baudClear = (state_q != TRANSMIT);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear_i(baudClear),
        .tick_o (baudTick)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitCnt_d = bitCnt_q;
        done_d   = done_q;
        unique case (state_q)
            IDLE: begin
                if (host.trmt) begin
                    shift_d  = loadFrame;
                    bitCnt_d = '0;
                    done_d   = 1'b0;
                    state_d  = TRANSMIT;
                end
            end
            TRANSMIT: begin
                if (baudTick) begin
                    shift_d  = {1'b1, shift_q[FRAME_BITS-1:1]};
                    bitCnt_d = bitCnt_q + 1'b1;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An all-ones shift register keeps the line idle-high straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shift_q  <= '1;
            bitCnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitCnt_q <= bitCnt_d;
            done_q   <= done_d;
        end
    end

    assign TX           = shift_q[0];
    assign host.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: bit-exact frame vectors, hand-written corner sequences,
// and a loopback receiver model that checks a byte scoreboard.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N    = 8;
    localparam int NVEC = 6;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       TX;
    uart_tx_if  bus ();

    int         checks = 0;
    int         errors = 0;
    int         resetCount = 0;
    int         rxCount = 0;
    int         pushedCount = 0;
    logic [7:0] expQ[$];
    vec_t       vecs[NVEC];

    uart_tx #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .host (bus),
        .TX   (TX)
    );

    always #5 clk = ~clk;

    always @(negedge rst_n) resetCount++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives trmt for exactly one cycle starting at the current negedge. Only frames the DUT should accept are pushed to the scoreboard.
    task automatic applyStimulus(input logic [7:0] data, input bit expectAccept);
        bus.trmt    = 1'b1;
        bus.tx_data = data;
        if (expectAccept) begin
            expQ.push_back(data);
            pushedCount++;
        end
        @(negedge clk);
        bus.trmt    = 1'b0;
        bus.tx_data = 8'($urandom);
    endtask

    function automatic logic expBit(input logic [7:0] d, input logic p, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
        if (FRAME_BITS == 11 && idx == 9) return p;
        return 1'b1;
    endfunction

    // Starts in cycle 1 of a frame and ends in the first idle cycle after it. mode 1 pulses trmt mid-frame; mode 2 pulses it in the last cycle of the stop bit.
    task automatic checkFrame(input logic [7:0] data, input logic par, input int mode);
        for (int c = 1; c <= FRAME_BITS * N; c++) begin
            if ((c - 1) % N == 0 || (c - 1) % N == N - 1)
                checkOutput($sformatf("bit%0d_of_%02h", (c - 1) / N, data), TX, expBit(data, par, (c - 1) / N));
            if (c == 1) checkOutput("done_clr_on_accept", bus.tx_done, 0);
            if (c == FRAME_BITS * N) checkOutput("done_not_early", bus.tx_done, 0);
            if (mode == 1 && c == 4 * N + 2) begin
                bus.trmt    = 1'b1;
                bus.tx_data = 8'h3C;
            end
            if (mode == 1 && c == 4 * N + 3) bus.trmt = 1'b0;
            if (mode == 2 && c == FRAME_BITS * N) begin
                bus.trmt    = 1'b1;
                bus.tx_data = 8'hC3;
            end
            @(negedge clk);
        end
        bus.trmt = 1'b0;
        checkOutput("done_rise", bus.tx_done, 1);
        checkOutput("stop_idle_high", TX, 1);
    endtask

    task automatic checkIdle(input string name, input int cycles, input logic expDone);
        int bad = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (TX !== 1'b1 || bus.tx_done !== expDone) bad++;
        end
        checkOutput(name, bad, 0);
    endtask

    task automatic waitDone();
        int k = 0;
        while (bus.tx_done !== 1'b1 && k < FRAME_BITS * N + 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput("done_timeout", bus.tx_done, 1);
    endtask

    // Receiver model: samples each bit at mid-period and drops any frame that a reset interrupted.
    initial begin
        int         snap;
        logic       startBit, stopBit, rxPar;
        logic [7:0] rxByte, exp;
        rxPar = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && TX === 1'b0) begin
                snap = resetCount;
                repeat (N / 2) @(negedge clk);
                startBit = TX;
                for (int i = 0; i < 8; i++) begin
                    repeat (N) @(negedge clk);
                    rxByte[i] = TX;
                end
                if (FRAME_BITS == 11) begin
                    repeat (N) @(negedge clk);
                    rxPar = TX;
                end
                repeat (N) @(negedge clk);
                stopBit = TX;
                if (snap == resetCount) begin
                    rxCount++;
                    checkOutput("rx_frame_expected", 32'(expQ.size() > 0), 1);
                    if (expQ.size() > 0) begin
                        exp = expQ.pop_front();
                        checkOutput("rx_start", startBit, 0);
                        checkOutput("rx_data", rxByte, exp);
                        checkOutput("rx_stop", stopBit, 1);
                        if (FRAME_BITS == 11) checkOutput("rx_parity", rxPar, ^exp);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] d;
        vecs[0] = '{8'hA5, 1'b0};
        vecs[1] = '{8'h00, 1'b0};
        vecs[2] = '{8'hFF, 1'b0};
        vecs[3] = '{8'h07, 1'b1};
        vecs[4] = '{8'h3C, 1'b0};
        vecs[5] = '{8'h80, 1'b1};

        bus.trmt    = 1'b0;
        bus.tx_data = 8'h00;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", TX, 1);
        checkOutput("reset_done", bus.tx_done, 0);
        rst_n = 1'b1;
        checkIdle("idle_hold", 10000, 1'b0);

        // Back-to-back table frames, each trmt issued on the first idle cycle.
        $display("[TB] table vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].data, 1'b1);
            checkFrame(vecs[i].data, vecs[i].par, 0);
        end

        $display("[TB] trmt during a frame");
        checkIdle("pre_mid_idle", 3, 1'b1);
        applyStimulus(8'hA5, 1'b1);
        checkFrame(8'hA5, 1'b0, 1);
        checkIdle("no_second_frame", 3 * N, 1'b1);

        $display("[TB] trmt on the return-to-idle cycle");
        applyStimulus(8'h5A, 1'b1);
        checkFrame(8'h5A, 1'b0, 2);
        checkIdle("return_cycle_ignored", 3 * N, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h86, 1'b0);
        repeat (5 * N + 3) @(negedge clk);
        checkOutput("pre_reset_tx_low", TX, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_tx", TX, 1);
        checkOutput("async_reset_done", bus.tx_done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checkIdle("post_reset_idle", 12 * N, 1'b0);
        applyStimulus(8'h3C, 1'b1);
        checkFrame(8'h3C, 1'b0, 0);

        $display("[TB] random loopback");
        repeat (256) begin
            d = 8'($urandom);
            applyStimulus(d, 1'b1);
            waitDone();
        end
        repeat (2 * N) @(negedge clk);
        checkOutput("rx_count", rxCount, pushedCount);
        checkOutput("scoreboard_empty", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
